// File: rtl/sync_filter_multi_pkg.sv
// Shared constants, helpers and types for the multi-channel synchronizer/filter.
package sync_pkg;

  // Shortest chain that still gives a metastable sample a full cycle to resolve.
  localparam int MIN_SYNC_STAGES = 2;

  // Width of a counter that can hold 0..filter_len.
  function automatic int cnt_width(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

  // Registered edge pulses of one channel.
  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

endpackage

// File: rtl/sync_filter_multi_ch.sv
// One channel: synchronizer chain, consecutive-sample glitch filter, edge pulses.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILTER_LEN = 3,
  parameter logic RESET_BIT  = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  async_in,
  output logic  sync_out,
  output logic  filt_out,
  output edge_t pulse
);

  localparam int              CW       = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("sync_filter_ch: STAGES must be >= %0d", MIN_SYNC_STAGES);
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("sync_filter_ch: FILTER_LEN must be >= 1");
  end

  logic [STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              filt_q, filt_d;
  edge_t             edge_q, edge_d;

  assign sync_out = sync_q[STAGES-1];
  assign filt_out = filt_q;
  assign pulse    = edge_q;

  // Plain shift chain; async_in only ever lands in stage 0.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
  end

  // Filter: a new level must be seen FILTER_LEN consecutive cycles before it is taken.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    edge_d = '0;
    if (sync_out != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d      = sync_out;
        edge_d.rise = sync_out;
        edge_d.fall = ~sync_out;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any count in progress and any pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_BIT}};
      cnt_q  <= '0;
      filt_q <= RESET_BIT;
      edge_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/sync_filter_multi.sv
// NUM_CH independent synchronize + debounce + edge-detect channels.
module sync_filter_multi
  import sync_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                STAGES     = 2,
  parameter int                FILTER_LEN = 3,
  parameter logic [NUM_CH-1:0] RESET_VAL  = {NUM_CH{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] filt_out,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              any_edge
);

  edge_t [NUM_CH-1:0] pulses;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_filter_ch #(
      .STAGES    (STAGES),
      .FILTER_LEN(FILTER_LEN),
      .RESET_BIT (RESET_VAL[i])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .async_in(async_in[i]),
      .sync_out(sync_out[i]),
      .filt_out(filt_out[i]),
      .pulse   (pulses[i])
    );
    assign rise[i] = pulses[i].rise;
    assign fall[i] = pulses[i].fall;
  end

  // Summary strobe straight off the registered pulses.
  always_comb begin
    any_edge = |(rise | fall);
  end

endmodule

// File: tb/tb_sync_filter_multi.sv
// Directed bench for sync_filter_multi with a pulse scoreboard on the default instance.
module tb_sync_filter_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // a: defaults, b: FILTER_LEN=4, c: STAGES=3 FILTER_LEN=1 RESET_VAL=0
  logic       rst_a, rst_b, rst_c;
  logic [3:0] in_a, in_b, in_c;
  logic [3:0] sync_a, filt_a, rise_a, fall_a;
  logic [3:0] sync_b, filt_b, rise_b, fall_b;
  logic [3:0] sync_c, filt_c, rise_c, fall_c;
  logic       any_a, any_b, any_c;

  sync_filter_multi u_dut_a (
    .clk(clk), .rst(rst_a), .async_in(in_a), .sync_out(sync_a), .filt_out(filt_a),
    .rise(rise_a), .fall(fall_a), .any_edge(any_a)
  );

  sync_filter_multi #(.NUM_CH(4), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(4'b1111)) u_dut_b (
    .clk(clk), .rst(rst_b), .async_in(in_b), .sync_out(sync_b), .filt_out(filt_b),
    .rise(rise_b), .fall(fall_b), .any_edge(any_b)
  );

  sync_filter_multi #(.NUM_CH(4), .STAGES(3), .FILTER_LEN(1), .RESET_VAL(4'b0000)) u_dut_c (
    .clk(clk), .rst(rst_c), .async_in(in_c), .sync_out(sync_c), .filt_out(filt_c),
    .rise(rise_c), .fall(fall_c), .any_edge(any_c)
  );

  localparam int LAT_A = 2 + 3;

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] f;
  } ev_t;

  ev_t        sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errs = 0;
  bit         mon_en = 1'b0;
  logic [3:0] exp_filt = 4'b1111;
  bit         hist[$];

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expect pulses on instance a at cycle 'at'; events landing on the same cycle merge.
  task automatic push(input int at, input logic [3:0] r, input logic [3:0] f);
    foreach (sb[i]) begin
      if (sb[i].cyc == at) begin
        sb[i].r = sb[i].r | r;
        sb[i].f = sb[i].f | f;
        return;
      end
    end
    sb.push_back('{at, r, f});
  endtask

  // Advance to the next falling edge and score instance a's outputs for that cycle.
  task automatic tick();
    logic [3:0] r, f;
    ev_t        e;
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      r = '0;
      f = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        r = e.r;
        f = e.f;
        exp_filt = exp_filt ^ (r | f);
      end
      chk4("rise_a", rise_a, r);
      chk4("fall_a", fall_a, f);
      chk4("filt_a", filt_a, exp_filt);
      chk1("any_edge_a", any_a, |(r | f));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit v;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    in_a  = 4'b0000; in_b = 4'b1111; in_c = 4'b0000;

    // 1: reset state, then release with inputs low -> all channels fall together
    run(3);
    chk4("rst_sync_a", sync_a, 4'b1111);
    chk4("rst_filt_a", filt_a, 4'b1111);
    chk4("rst_rise_a", rise_a, 4'b0000);
    chk4("rst_fall_a", fall_a, 4'b0000);
    chk1("rst_any_a", any_a, 1'b0);
    chk4("rst_filt_c", filt_c, 4'b0000);
    chk4("rst_sync_b", sync_b, 4'b1111);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    mon_en = 1'b1;
    push(cyc + LAT_A, 4'b0000, 4'b1111);
    run(LAT_A + 2);

    // 2: ch0 rises; synchronizer latency then full filter latency
    in_a[0] = 1'b1;
    push(cyc + LAT_A, 4'b0001, 4'b0000);
    tick();
    chk1("sync0_edge1", sync_a[0], 1'b0);
    tick();
    chk1("sync0_edge2", sync_a[0], 1'b1);
    run(LAT_A);

    // 3: two-cycle glitch on ch1 is swallowed; three-cycle pulse passes both edges
    in_a[1] = 1'b1;
    run(2);
    in_a[1] = 1'b0;
    run(8);
    in_a[1] = 1'b1;
    push(cyc + LAT_A, 4'b0010, 4'b0000);
    run(3);
    in_a[1] = 1'b0;
    push(cyc + LAT_A, 4'b0000, 4'b0010);
    run(LAT_A + 2);

    // 4: raise ch3, then ch2 rises and ch3 falls on the same edge
    in_a[3] = 1'b1;
    push(cyc + LAT_A, 4'b1000, 4'b0000);
    run(LAT_A + 1);
    in_a[2] = 1'b1;
    in_a[3] = 1'b0;
    push(cyc + LAT_A, 4'b0100, 4'b1000);
    run(LAT_A + 2);

    // 5: instance b, reset while ch2 is mid-count, then the count starts over
    in_b[2] = 1'b0;
    run(4);
    chk4("b_filt_midcount", filt_b, 4'b1111);
    #2 rst_b = 1'b1;
    #1;
    chk4("b_rst_sync_async", sync_b, 4'b1111);
    chk4("b_rst_filt_async", filt_b, 4'b1111);
    chk4("b_rst_fall_async", fall_b, 4'b0000);
    chk4("b_rst_rise_async", rise_b, 4'b0000);
    tick();
    rst_b = 1'b0;
    run(5);
    chk4("b_filt_before_thresh", filt_b, 4'b1111);
    chk4("b_fall_before_thresh", fall_b, 4'b0000);
    tick();
    chk4("b_filt_after_thresh", filt_b, 4'b1011);
    chk4("b_fall_after_thresh", fall_b, 4'b0100);
    tick();
    chk4("b_fall_one_cycle", fall_b, 4'b0000);

    // 6: instance c, ch0 step (3 + 1 edges), then a metastable stream on ch3
    in_c[0] = 1'b1;
    run(3);
    chk1("c_filt0_edge3", filt_c[0], 1'b0);
    chk4("c_rise_edge3", rise_c, 4'b0000);
    tick();
    chk1("c_filt0_edge4", filt_c[0], 1'b1);
    chk4("c_rise_edge4", rise_c, 4'b0001);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk1("c_filt3_known", $isunknown(filt_c[3]), 1'b0);
      if (i >= 4) chk1("c_filt3_follow", filt_c[3], hist[i-4]);
      // Each x sample is modelled as having decayed to a random legal level in stage 1.
      v = 1'($urandom_range(1, 0));
      in_c[3] = v;
      hist.push_back(v);
    end

    chk4("sb_drained", 4'(sb.size()), 4'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
